// File: rtl/lif_neuron_integrator_pkg.sv
// Shared neuron-side definitions: datapath width, integrator FSM encoding
// and a signed saturating adder for blocks fixed at the default width.
package lif_neuron_integrator_pkg;

   localparam int SNN_DATA_W = 32;

   typedef enum logic [1:0] {
      ST_ACCUM  = 2'd0,
      ST_UPDATE = 2'd1,
      ST_FIRE   = 2'd2
   } lif_state_e;

   // Signed add that clamps to the most positive / most negative value
   // instead of wrapping when both operands share a sign and the result flips.
   function automatic logic signed [SNN_DATA_W-1:0] sat_add(
      input logic signed [SNN_DATA_W-1:0] a,
      input logic signed [SNN_DATA_W-1:0] b
   );
      logic signed [SNN_DATA_W-1:0] raw;
      raw = a + b;
      if ((a[SNN_DATA_W-1] == b[SNN_DATA_W-1]) && (raw[SNN_DATA_W-1] != a[SNN_DATA_W-1])) begin
         if (a[SNN_DATA_W-1]) begin
            sat_add = {1'b1, {(SNN_DATA_W-1){1'b0}}};
         end else begin
            sat_add = {1'b0, {(SNN_DATA_W-1){1'b1}}};
         end
      end else begin
         sat_add = raw;
      end
   endfunction

endpackage

// File: rtl/lif_neuron_integrator_if.sv
// MAC-side and spike-side handshake bundle of one LIF neuron, plus the
// threshold input and the observable membrane state.
interface lif_neuron_integrator_if
   import lif_neuron_integrator_pkg::*;
#(
   parameter int DATA_W = SNN_DATA_W
);
   logic signed [DATA_W-1:0] mac_sum;
   logic                     mac_valid;
   logic                     mac_ready;
   logic                     ts_end;
   logic signed [DATA_W-1:0] threshold;
   logic                     spike_valid;
   logic                     spike_ready;
   logic                     ts_done;
   logic signed [DATA_W-1:0] v_mem;
   logic                     refractory;

   // Upstream MAC / timestep controller / spike consumer side
   modport master (
      output mac_sum, mac_valid, ts_end, threshold, spike_ready,
      input  mac_ready, spike_valid, ts_done, v_mem, refractory
   );

   // Neuron integrator side
   modport slave (
      input  mac_sum, mac_valid, ts_end, threshold, spike_ready,
      output mac_ready, spike_valid, ts_done, v_mem, refractory
   );
endinterface

// File: rtl/lif_neuron_integrator_sat_add.sv
// Width-generic signed saturating adder used for the beat accumulator and
// for the membrane update.
module lif_neuron_integrator_sat_add #(
   parameter int W = 32
) (
   input  logic signed [W-1:0] a_i,
   input  logic signed [W-1:0] b_i,
   output logic signed [W-1:0] sum_o
);
   logic signed [W-1:0] raw_s;
   logic                ovf_s;

   // Wrap-around sum, then clamp when same-sign operands overflow
   always_comb begin
      raw_s = a_i + b_i;
      ovf_s = (a_i[W-1] == b_i[W-1]) && (raw_s[W-1] != a_i[W-1]);
      if (ovf_s) begin
         if (a_i[W-1]) begin
            sum_o = {1'b1, {(W-1){1'b0}}};
         end else begin
            sum_o = {1'b0, {(W-1){1'b1}}};
         end
      end else begin
         sum_o = raw_s;
      end
   end
endmodule

// File: rtl/lif_neuron_integrator.sv
// Leaky integrate-and-fire neuron: sums MAC beats over a timestep, applies
// leak + threshold at timestep end, and hands spikes to the packetizer.
module lif_neuron_integrator
   import lif_neuron_integrator_pkg::*;
#(
   parameter int                       DATA_W     = SNN_DATA_W,
   parameter int unsigned              LEAK_SHIFT = 3,
   parameter int unsigned              REFRAC_TS  = 2,
   parameter logic signed [DATA_W-1:0] V_RESET    = {DATA_W{1'b0}}
) (
   input logic                    clk,
   input logic                    reset,
   lif_neuron_integrator_if.slave bus
);
   localparam int REFR_W = (REFRAC_TS > 1) ? $clog2(REFRAC_TS + 1) : 1;

   lif_state_e               state_q, state_d;
   logic signed [DATA_W-1:0] acc_q, acc_d;
   logic signed [DATA_W-1:0] v_q, v_d;
   logic [REFR_W-1:0]        refr_q, refr_d;
   logic                     mac_ready_q, mac_ready_d;
   logic                     spike_valid_q, spike_valid_d;
   logic                     ts_done_q, ts_done_d;
   logic                     refractory_q, refractory_d;

   logic signed [DATA_W-1:0] acc_sum_s;
   logic signed [DATA_W-1:0] leak_s;
   logic signed [DATA_W-1:0] leaked_s;
   logic signed [DATA_W-1:0] v_new_s;
   logic                     fire_s;

   lif_neuron_integrator_sat_add #(.W(DATA_W)) u_acc_add (
      .a_i   (acc_q),
      .b_i   (bus.mac_sum),
      .sum_o (acc_sum_s)
   );

   // v - (v >>> s) cannot overflow for s >= 1, so only the acc add saturates
   lif_neuron_integrator_sat_add #(.W(DATA_W)) u_v_add (
      .a_i   (leaked_s),
      .b_i   (acc_q),
      .sum_o (v_new_s)
   );

   // Leak term and firing decision from the current membrane value
   always_comb begin
      if (LEAK_SHIFT == 0) begin
         leak_s = {DATA_W{1'b0}};
      end else begin
         leak_s = v_q >>> LEAK_SHIFT;
      end
      leaked_s = v_q - leak_s;
      fire_s   = (v_new_s >= bus.threshold);
   end

   // Next-state and datapath updates for ACCUM / UPDATE / FIRE
   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      v_d       = v_q;
      refr_d    = refr_q;
      ts_done_d = 1'b0;
      case (state_q)
         ST_ACCUM: begin
            if (bus.mac_valid) begin
               acc_d = acc_sum_s;
            end else begin
               acc_d = acc_q;
            end
            if (bus.ts_end) begin
               state_d = ST_UPDATE;
            end else begin
               state_d = ST_ACCUM;
            end
         end
         ST_UPDATE: begin
            acc_d = {DATA_W{1'b0}};
            if (refr_q != {REFR_W{1'b0}}) begin
               // Refractory timestep: input is discarded, membrane pinned
               v_d       = V_RESET;
               refr_d    = refr_q - REFR_W'(1'b1);
               state_d   = ST_ACCUM;
               ts_done_d = 1'b1;
            end else if (fire_s) begin
               v_d     = V_RESET;
               refr_d  = REFR_W'(REFRAC_TS);
               state_d = ST_FIRE;
            end else begin
               v_d       = v_new_s;
               state_d   = ST_ACCUM;
               ts_done_d = 1'b1;
            end
         end
         ST_FIRE: begin
            // spike_valid is high throughout FIRE, so ready alone completes it
            if (bus.spike_ready) begin
               state_d   = ST_ACCUM;
               ts_done_d = 1'b1;
            end else begin
               state_d = ST_FIRE;
            end
         end
         default: begin
            state_d = ST_ACCUM;
            acc_d   = {DATA_W{1'b0}};
         end
      endcase
      mac_ready_d   = (state_d == ST_ACCUM);
      spike_valid_d = (state_d == ST_FIRE);
      refractory_d  = (refr_d != {REFR_W{1'b0}});
   end

   // State and output registers; reset discards any pending spike
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= ST_ACCUM;
         acc_q         <= {DATA_W{1'b0}};
         v_q           <= V_RESET;
         refr_q        <= {REFR_W{1'b0}};
         mac_ready_q   <= 1'b1;
         spike_valid_q <= 1'b0;
         ts_done_q     <= 1'b0;
         refractory_q  <= 1'b0;
      end else begin
         state_q       <= state_d;
         acc_q         <= acc_d;
         v_q           <= v_d;
         refr_q        <= refr_d;
         mac_ready_q   <= mac_ready_d;
         spike_valid_q <= spike_valid_d;
         ts_done_q     <= ts_done_d;
         refractory_q  <= refractory_d;
      end
   end

   assign bus.mac_ready   = mac_ready_q;
   assign bus.spike_valid = spike_valid_q;
   assign bus.ts_done     = ts_done_q;
   assign bus.v_mem       = v_q;
   assign bus.refractory  = refractory_q;
endmodule

// File: tb/tb_lif_neuron_integrator.sv
// Scenario bench for lif_neuron_integrator: a reference neuron model pushes
// the expected timestep outcome; it is popped when the DUT reports the result.
module tb_lif_neuron_integrator;

   localparam int M_LEAK   = 3;
   localparam int M_REFRAC = 2;

   typedef struct packed {
      logic               spike;
      logic signed [31:0] v;
      logic               refr;
   } exp_t;

   logic clk = 1'b0;
   logic reset;

   lif_neuron_integrator_if #(.DATA_W(32)) bus ();

   lif_neuron_integrator dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int vectors    = 0;
   int miscompares = 0;

   logic signed [31:0] stim_q[$];
   exp_t               exp_q[$];
   logic signed [31:0] m_v;
   int                 m_refr;
   logic signed [31:0] m_thr;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic signed [31:0] msat(input longint s);
      logic signed [63:0] t;
      t = s;
      if (s > 64'sd2147483647) return 32'sh7FFFFFFF;
      else if (s < -64'sd2147483648) return 32'sh80000000;
      else return t[31:0];
   endfunction

   // Reference model of one timestep over stim_q; pushes the expected outcome
   task automatic model_push();
      logic signed [31:0] acc;
      logic signed [31:0] vn;
      exp_t e;
      acc = 32'sd0;
      foreach (stim_q[i]) acc = msat(longint'(acc) + longint'(stim_q[i]));
      e.spike = 1'b0;
      if (m_refr != 0) begin
         m_v    = 32'sd0;
         m_refr = m_refr - 1;
      end else begin
         vn = msat(longint'(m_v) - longint'(m_v >>> M_LEAK) + longint'(acc));
         if (vn >= m_thr) begin
            e.spike = 1'b1;
            m_v     = 32'sd0;
            m_refr  = M_REFRAC;
         end else begin
            m_v = vn;
         end
      end
      e.v    = m_v;
      e.refr = (m_refr != 0);
      exp_q.push_back(e);
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      bus.mac_valid = 1'b0; bus.ts_end = 1'b0; bus.spike_ready = 1'b0;
      tick();
      reset = 1'b0;
      m_v = 32'sd0; m_refr = 0;
      exp_q.delete();
   endtask

   task automatic set_thr(input logic signed [31:0] t);
      m_thr = t;
      bus.threshold = t;
   endtask

   // Drive stim_q as one timestep and check the outcome at ts_end + 2
   task automatic run_ts(input bit coincident, input int hold, input bit ts_end_in_fire);
      exp_t e;
      int   n;
      model_push();
      n = stim_q.size();
      for (int i = 0; i < n; i++) begin
         bus.mac_valid = 1'b1;
         bus.mac_sum   = stim_q[i];
         bus.ts_end    = coincident && (i == n - 1);
         vectors++;
         if (bus.mac_ready !== 1'b1) begin
            miscompares++; $display("FAIL accum_mac_ready: got %b want 1", bus.mac_ready);
         end
         tick();
      end
      if (!coincident || n == 0) begin
         bus.mac_valid = 1'b0;
         bus.ts_end    = 1'b1;
         tick();
      end
      bus.mac_valid = 1'b0;
      bus.ts_end    = 1'b0;
      vectors++;
      if (bus.mac_ready !== 1'b0 || bus.spike_valid !== 1'b0 || bus.ts_done !== 1'b0) begin
         miscompares++;
         $display("FAIL update_outputs: got ready=%b spike=%b done=%b want 0 0 0",
                  bus.mac_ready, bus.spike_valid, bus.ts_done);
      end
      tick();
      e = exp_q.pop_front();
      vectors++;
      if (bus.spike_valid !== e.spike || bus.ts_done !== !e.spike) begin
         miscompares++;
         $display("FAIL result_latency: got spike=%b done=%b want spike=%b done=%b",
                  bus.spike_valid, bus.ts_done, e.spike, !e.spike);
      end
      vectors++;
      if (bus.v_mem !== e.v || bus.refractory !== e.refr) begin
         miscompares++;
         $display("FAIL membrane: got v=%0h refr=%b want v=%0h refr=%b",
                  bus.v_mem, bus.refractory, e.v, e.refr);
      end
      if (e.spike) begin
         for (int k = 0; k < hold; k++) begin
            vectors++;
            if (bus.spike_valid !== 1'b1 || bus.mac_ready !== 1'b0 || bus.ts_done !== 1'b0) begin
               miscompares++;
               $display("FAIL fire_hold: cycle %0d got spike=%b ready=%b done=%b want 1 0 0",
                        k, bus.spike_valid, bus.mac_ready, bus.ts_done);
            end
            if (ts_end_in_fire && k == 0) begin
               bus.ts_end = 1'b1; bus.mac_valid = 1'b1; bus.mac_sum = 32'sd1000;
            end else begin
               bus.ts_end = 1'b0; bus.mac_valid = 1'b0;
            end
            tick();
         end
         bus.ts_end = 1'b0; bus.mac_valid = 1'b0;
         bus.spike_ready = 1'b1;
         tick();
         bus.spike_ready = 1'b0;
         vectors++;
         if (bus.ts_done !== 1'b1 || bus.spike_valid !== 1'b0 || bus.mac_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL post_handshake: got done=%b spike=%b ready=%b want 1 0 1",
                     bus.ts_done, bus.spike_valid, bus.mac_ready);
         end
      end
      tick();
      vectors++;
      if (bus.ts_done !== 1'b0 || bus.mac_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL done_pulse_width: got done=%b ready=%b want 0 1", bus.ts_done, bus.mac_ready);
      end
      stim_q.delete();
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick(); tick();
      reset = 1'b0;
      m_v = 32'sd0; m_refr = 0;
      vectors++;
      if (bus.mac_ready !== 1'b1 || bus.spike_valid !== 1'b0 || bus.ts_done !== 1'b0 ||
          bus.v_mem !== 32'sd0 || bus.refractory !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_state: got ready=%b spike=%b done=%b v=%0h refr=%b want 1 0 0 0 0",
                  bus.mac_ready, bus.spike_valid, bus.ts_done, bus.v_mem, bus.refractory);
      end
   endtask

   task automatic test_integrate_then_spike();
      set_thr(32'sd100);
      stim_q = '{32'sd30, 32'sd40};
      run_ts(1'b0, 0, 1'b0);                 // v = 70, no spike
      stim_q = '{32'sd50};
      run_ts(1'b1, 0, 1'b0);                 // 70-8+50 = 112 -> spike, coincident beat
   endtask

   task automatic test_refractory();
      for (int t = 0; t < 3; t++) begin
         stim_q = '{32'sd200};
         run_ts(t[0], 1, 1'b0);              // two discarded timesteps, then spike
      end
   endtask

   task automatic test_saturation();
      apply_reset();
      set_thr(32'sh7FFFFFFF);
      stim_q = '{32'sh80000010, 32'shFFFFFF00};
      run_ts(1'b0, 0, 1'b0);                 // acc clamps to 0x80000000
      stim_q = '{32'sh7FFFFFF0, 32'sh00000100};
      run_ts(1'b1, 0, 1'b0);                 // acc clamps to 0x7FFFFFFF -> v 0x0FFFFFFF
      stim_q = '{32'sh7FFFFFFF, 32'sh7FFFFFFF};
      run_ts(1'b0, 2, 1'b0);                 // v_new clamps to max, equals threshold -> spike
   endtask

   task automatic test_backpressure();
      apply_reset();
      set_thr(32'sd100);
      stim_q = '{32'sd150};
      run_ts(1'b1, 5, 1'b1);                 // ready low 5 cycles, ts_end pulsed in FIRE
      for (int k = 0; k < 3; k++) begin
         vectors++;
         if (bus.ts_done !== 1'b0 || bus.mac_ready !== 1'b1 || bus.spike_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL fire_ts_end_ignored: got done=%b ready=%b spike=%b want 0 1 0",
                     bus.ts_done, bus.mac_ready, bus.spike_valid);
         end
         tick();
      end
   endtask

   task automatic test_reset_in_update();
      apply_reset();
      set_thr(32'sd100);
      bus.mac_valid = 1'b1; bus.mac_sum = 32'sd500; bus.ts_end = 1'b1;
      tick();                                // now in UPDATE
      bus.mac_valid = 1'b0; bus.ts_end = 1'b0;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      m_v = 32'sd0; m_refr = 0;
      for (int k = 0; k < 2; k++) begin
         vectors++;
         if (bus.spike_valid !== 1'b0 || bus.v_mem !== 32'sd0 || bus.mac_ready !== 1'b1 ||
             bus.refractory !== 1'b0 || bus.ts_done !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_in_update: cycle %0d got spike=%b v=%0h ready=%b refr=%b done=%b want 0 0 1 0 0",
                     k, bus.spike_valid, bus.v_mem, bus.mac_ready, bus.refractory, bus.ts_done);
         end
         tick();
      end
      stim_q = '{32'sd30};
      run_ts(1'b0, 0, 1'b0);                 // accumulator was cleared: v = 30
   endtask

   initial begin
      reset = 1'b1;
      bus.mac_sum = 32'sd0; bus.mac_valid = 1'b0; bus.ts_end = 1'b0;
      bus.spike_ready = 1'b0; bus.threshold = 32'sd100;
      m_thr = 32'sd100;
      test_reset();
      test_integrate_then_spike();
      test_refractory();
      test_saturation();
      test_backpressure();
      test_reset_in_update();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
      $fatal(1, "watchdog expired");
   end

endmodule
